// File: rtl/csr_intr_unit.sv
// csr_intr_unit: machine-mode CSR file and external-interrupt front end.
// Synchronises intr_ext, latches it as pending, and gates it with mstatus.MIE,
// mie.MEIE and the in-service state. It also holds mtvec/mepc for the PC mux.
// Optional feature: define CSR_MCYCLE_EN to add a free-running mcycle at 0xB00.
// Without it, 0xB00 reads 0 and writes to it are ignored.
module csr_intr_unit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TRIG   = 1,
    parameter logic [31:0] MTVEC_RST   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        intr_ext,
    input  logic        csr_we,
    input  logic        int_taken,
    input  logic        mret_exec,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    input  logic [31:0] pc,
    output logic [31:0] csr_rd,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        mie_bit,
    output logic        intr
);

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
`endif

    localparam logic [XLEN-1:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   sync_d_q;
    logic                   edge_det;
    logic                   pending_q, pending_d;

    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_meie_q,     mie_meie_d;
    logic [XLEN-1:0] mtvec_q,  mtvec_d;
    logic [XLEN-1:0] mepc_q,   mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic take;

    // int_taken only counts as an interrupt entry when not already in service.
    assign take     = int_taken & (state_q == IDLE);
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~sync_d_q;

    // Interrupt FSM next state: enter on accepted entry, leave on MRET.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)      state_d = SERVICE;
            SERVICE: if (mret_exec) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Pending latch: a new edge wins over a same-cycle clear so no event is lost.
    always_comb begin
        pending_d = pending_q;
        if (EDGE_TRIG != 0) begin
            pending_d = edge_det | (pending_q & ~take);
        end else begin
            pending_d = sync_out;
        end
    end

    // CSR next values with priority int_taken > mret_exec > csr_we per register.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (take) begin
            mepc_d         = pc & ALIGN_MASK;
            mcause_d       = MCAUSE_MEI;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_exec) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    if (!take && !mret_exec) begin
                        mstatus_mie_d  = csr_wd[3];
                        mstatus_mpie_d = csr_wd[7];
                    end
                end
                ADDR_MIE:    mie_meie_d = csr_wd[11];
                ADDR_MTVEC:  mtvec_d    = csr_wd & ALIGN_MASK;
                ADDR_MEPC:   if (!take) mepc_d   = csr_wd & ALIGN_MASK;
                ADDR_MCAUSE: if (!take) mcause_d = csr_wd;
                default: ;
            endcase
        end
    end

`ifdef CSR_MCYCLE_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;

    // Cycle counter: a write loads the value instead of incrementing.
    always_comb begin
        mcycle_d = mcycle_q + XLEN'(1);
        if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
            mcycle_d = csr_wd;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    // State, synchroniser and CSR registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            sync_d_q       <= 1'b0;
            pending_q      <= 1'b0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST & ALIGN_MASK;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            state_q        <= state_d;
            sync_q         <= {sync_q[SYNC_STAGES-2:0], intr_ext};
            sync_d_q       <= sync_out;
            pending_q      <= pending_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    // Side-effect-free read mux; unmapped addresses return zero.
    always_comb begin
        csr_rd = '0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rd = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            ADDR_MIE:     csr_rd = {20'h0, mie_meie_q, 11'h0};
            ADDR_MTVEC:   csr_rd = mtvec_q;
            ADDR_MEPC:    csr_rd = mepc_q;
            ADDR_MCAUSE:  csr_rd = mcause_q;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  csr_rd = mcycle_q;
`endif
            default:      csr_rd = '0;
        endcase
    end

    assign mtvec   = mtvec_q;
    assign mepc    = mepc_q;
    assign mie_bit = mstatus_mie_q;
    assign intr    = pending_q & mstatus_mie_q & mie_meie_q & (state_q == IDLE);

endmodule

// File: tb/tb_csr_intr_unit.sv
// Scoreboard bench for csr_intr_unit: stimulus pushes cycle-stamped expectations,
// and a monitor on the falling edge pops and compares them.
module tb_csr_intr_unit;

    localparam int unsigned SYNC = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0107;
    localparam logic [31:0] MTVEC_RST_EXP = 32'h0000_0104;

    localparam int unsigned SEL_RD    = 0;
    localparam int unsigned SEL_MTVEC = 1;
    localparam int unsigned SEL_MEPC  = 2;
    localparam int unsigned SEL_MIE   = 3;
    localparam int unsigned SEL_INTR  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        intr_ext;
    logic        csr_we;
    logic        int_taken;
    logic        mret_exec;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic [31:0] csr_rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_bit;
    logic        intr;

    csr_intr_unit #(
        .SYNC_STAGES(SYNC),
        .EDGE_TRIG  (1),
        .MTVEC_RST  (MTVEC_RST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .intr_ext (intr_ext),
        .csr_we   (csr_we),
        .int_taken(int_taken),
        .mret_exec(mret_exec),
        .csr_addr (csr_addr),
        .csr_wd   (csr_wd),
        .pc       (pc),
        .csr_rd   (csr_rd),
        .mtvec    (mtvec),
        .mepc     (mepc),
        .mie_bit  (mie_bit),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc_cnt  = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Cycle stamp used to schedule expectations.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            SEL_RD:    return csr_rd;
            SEL_MTVEC: return mtvec;
            SEL_MEPC:  return mepc;
            SEL_MIE:   return {31'h0, mie_bit};
            default:   return {31'h0, intr};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc_cnt) begin
                    e = sb_q[i];
                    sb_q.delete(i);
                    n_checks++;
                    if (e.cyc < cyc_cnt) begin
                        n_fail++;
                        $display("FAIL %s: missed at cycle %0d (now %0d)", e.name, e.cyc, cyc_cnt);
                    end else begin
                        act = observe(e.sel);
                        if (act !== e.exp) begin
                            n_fail++;
                            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                                     e.name, act, e.exp, cyc_cnt);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned dly, input int unsigned sel,
                             input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc_cnt + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        csr_addr = addr;
        expect_at(0, SEL_RD, exp, name);
        step(1);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_we   = 1'b1;
        csr_addr = addr;
        csr_wd   = data;
        step(1);
        csr_we   = 1'b0;
    endtask

    task automatic pulse_take(input logic [31:0] pc_val);
        int_taken = 1'b1;
        pc        = pc_val;
        step(1);
        int_taken = 1'b0;
    endtask

    task automatic pulse_mret();
        mret_exec = 1'b1;
        step(1);
        mret_exec = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        rst_n     = 1'b0;
        intr_ext  = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        csr_addr  = 12'h0;
        csr_wd    = 32'h0;
        pc        = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        expect_at(0, SEL_MTVEC, MTVEC_RST_EXP, "rst_mtvec");
        expect_at(0, SEL_MEPC,  32'h0, "rst_mepc");
        expect_at(0, SEL_INTR,  32'h0, "rst_intr");
        expect_at(0, SEL_MIE,   32'h0, "rst_mie_bit");
        rd(12'h300, 32'h0, "rst_mstatus");
        rd(12'h304, 32'h0, "rst_mie");
        rd(12'h341, 32'h0, "rst_mepc_rd");
        rd(12'h342, 32'h0, "rst_mcause");
        rd(12'h305, MTVEC_RST_EXP, "rst_mtvec_rd");
        rd(12'h7C0, 32'h0, "rst_unmapped");

        // Enable the interrupt path.
        wr(12'h305, 32'h0000_1003);
        expect_at(0, SEL_MTVEC, 32'h0000_1000, "mtvec_wr");
        wr(12'h300, 32'h0000_0008);
        wr(12'h304, 32'h0000_0800);
        expect_at(0, SEL_MIE,  32'h1, "mie_bit_set");
        expect_at(0, SEL_INTR, 32'h0, "intr_idle");
        rd(12'h300, 32'h0000_0008, "mstatus_rd");
        rd(12'h304, 32'h0000_0800, "mie_rd");

        // Pin rises in cycle 1; intr appears in cycle SYNC+2 (after SYNC+1 edges) and stays.
        intr_ext = 1'b1;
        for (int k = 0; k <= int'(SYNC); k++) expect_at(k, SEL_INTR, 32'h0, "intr_lat_lo");
        expect_at(SYNC + 1, SEL_INTR, 32'h1, "intr_lat_hi");
        expect_at(SYNC + 3, SEL_INTR, 32'h1, "intr_held");
        step(1);
        intr_ext = 1'b0;
        step(SYNC + 2);

        // Interrupt entry.
        pulse_take(32'h0000_0206);
        expect_at(0, SEL_MEPC, 32'h0000_0204, "take_mepc");
        expect_at(0, SEL_INTR, 32'h0, "take_intr");
        expect_at(0, SEL_MIE,  32'h0, "take_mie_bit");
        rd(12'h342, 32'h8000_000B, "take_mcause");
        rd(12'h300, 32'h0000_0080, "take_mstatus");
        rd(12'h341, 32'h0000_0204, "take_mepc_rd");

        // int_taken in service is ignored.
        pulse_take(32'h0000_0300);
        rd(12'h341, 32'h0000_0204, "svc_take_mepc");
        rd(12'h300, 32'h0000_0080, "svc_take_mstatus");

        // New event during service stays pending across MRET.
        intr_ext = 1'b1;
        step(1);
        intr_ext = 1'b0;
        step(SYNC + 2);
        expect_at(0, SEL_INTR, 32'h0, "svc_intr_masked");
        pulse_mret();
        expect_at(0, SEL_INTR, 32'h1, "mret_intr");
        expect_at(0, SEL_MIE,  32'h1, "mret_mie_bit");
        rd(12'h300, 32'h0000_0088, "mret_mstatus");

        // Entry beats a same-cycle mepc write.
        int_taken = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = 12'h341;
        csr_wd    = 32'hDEAD_BEEF;
        pc        = 32'h0000_0410;
        step(1);
        int_taken = 1'b0;
        csr_we    = 1'b0;
        expect_at(0, SEL_MEPC, 32'h0000_0410, "prio_mepc");
        expect_at(0, SEL_INTR, 32'h0, "prio_intr");
        rd(12'h300, 32'h0000_0080, "prio_mstatus");
        pulse_mret();
        expect_at(0, SEL_INTR, 32'h0, "cleared_intr");
        rd(12'h300, 32'h0000_0088, "cleared_mstatus");

        // Edge coinciding with int_taken is kept pending.
        intr_ext = 1'b1;
        step(1);
        intr_ext = 1'b0;
        step(SYNC - 1);
        pulse_take(32'h0000_0500);
        expect_at(0, SEL_MEPC, 32'h0000_0500, "coinc_mepc");
        expect_at(0, SEL_INTR, 32'h0, "coinc_intr_lo");
        pulse_mret();
        expect_at(0, SEL_INTR, 32'h1, "coinc_intr_kept");

        // Write masking per register.
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, 32'h0000_0088, "mstatus_mask");
        wr(12'h300, 32'h0000_0000);
        expect_at(0, SEL_INTR, 32'h0, "mstatus_clr_intr");
        wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, 32'h0000_0800, "mie_mask");
        wr(12'h341, 32'h0000_1003);
        expect_at(0, SEL_MEPC, 32'h0000_1000, "mepc_wr");
        wr(12'h342, 32'h1234_5679);
        rd(12'h342, 32'h1234_5679, "mcause_wr");
        wr(12'h7C0, 32'h0000_FFFF);
        rd(12'h7C0, 32'h0, "unmapped_wr");
        rd(12'h305, 32'h0000_1000, "mtvec_kept");

        // MRET while idle restores MIE from MPIE.
        pulse_mret();
        rd(12'h300, 32'h0000_0080, "idle_mret1");
        pulse_mret();
        expect_at(0, SEL_INTR, 32'h1, "idle_mret_intr");
        rd(12'h300, 32'h0000_0088, "idle_mret2");

`ifdef CSR_MCYCLE_EN
        wr(12'hB00, 32'hFFFF_FFFE);
        csr_addr = 12'hB00;
        expect_at(0, SEL_RD, 32'hFFFF_FFFE, "mcycle_load");
        expect_at(1, SEL_RD, 32'hFFFF_FFFF, "mcycle_inc");
        expect_at(2, SEL_RD, 32'h0000_0000, "mcycle_wrap");
        expect_at(3, SEL_RD, 32'h0000_0001, "mcycle_after");
        step(4);
`else
        wr(12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00, 32'h0, "mcycle_absent");
`endif

        // Reset while in service with an edge in flight.
        pulse_take(32'h0000_0700);
        expect_at(0, SEL_MEPC, 32'h0000_0700, "svc2_mepc");
        intr_ext = 1'b1;
        step(1);
        intr_ext = 1'b0;
        step(SYNC - 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        expect_at(0, SEL_MEPC,  32'h0, "rst2_mepc");
        expect_at(0, SEL_MTVEC, MTVEC_RST_EXP, "rst2_mtvec");
        expect_at(0, SEL_MIE,   32'h0, "rst2_mie_bit");
        rd(12'h342, 32'h0, "rst2_mcause");
        wr(12'h300, 32'h0000_0008);
        wr(12'h304, 32'h0000_0800);
        step(SYNC + 2);
        expect_at(0, SEL_INTR, 32'h0, "rst2_no_pending");
        pulse_take(32'h0000_0604);
        expect_at(0, SEL_MEPC, 32'h0000_0604, "rst2_idle_take");
        step(1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) step(1);
        while (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked (due cycle %0d)", sb_q[0].name, sb_q[0].cyc);
            sb_q.delete(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
